// File: rtl/xeng_acc_unload.sv
// Unload end of the X-engine accumulator chain: frames words into N_TAPS-word dumps and buffers them in an FWFT FIFO.
// Optional build macro XENG_UNLOAD_DROPCNT_EN enables the saturating dropped-word counter on drop_cnt.
module xeng_acc_unload #(
    parameter int ACC_BITS        = 19,
    parameter int N_TAPS_BITS     = 4,
    parameter int FIFO_DEPTH_BITS = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  sync,
    input  logic [2*ACC_BITS-1:0] acc_in,
    input  logic                  valid_in,
    output logic [2*ACC_BITS-1:0] dout,
    output logic                  dout_last,
    output logic                  dout_valid,
    input  logic                  dout_ready,
    output logic [15:0]           dump_cnt,
    output logic                  overflow,
    output logic                  misalign,
    output logic [15:0]           drop_cnt
);
    localparam int W     = 2 * ACC_BITS;
    localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
    localparam int PW    = FIFO_DEPTH_BITS + 1;

    typedef enum logic {S_WAIT_SYNC, S_RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [N_TAPS_BITS-1:0] r_word_ctr;
    logic [W:0]             r_mem [DEPTH];
    logic [PW-1:0]          r_wptr;
    logic [PW-1:0]          r_rptr;
    logic [PW-1:0]          r_count;
    logic [W-1:0]           r_dout;
    logic                   r_dout_last;
    logic                   r_dout_valid;
    logic [15:0]            r_dump_cnt;
    logic                   r_overflow;
    logic                   r_misalign;

    logic [N_TAPS_BITS-1:0] w_idx;
    logic                   w_last;
    logic                   w_wr_try;
    logic                   w_wr;
    logic                   w_rd;
    logic                   w_full;
    logic                   w_load;
    logic [W:0]             w_head;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_WAIT_SYNC;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_SYNC: if (sync) w_state_nxt = S_RUN;
            S_RUN:       w_state_nxt = S_RUN;
            default:     w_state_nxt = S_WAIT_SYNC;
        endcase
    end

    // A sync word restarts framing at index 0 even when the previous dump is incomplete
    assign w_idx    = sync ? '0 : r_word_ctr;
    assign w_last   = &w_idx;
    assign w_wr_try = (r_state == S_RUN) && valid_in;
    assign w_rd     = r_dout_valid && dout_ready;
    assign w_full   = (r_count == PW'(DEPTH));
    assign w_wr     = w_wr_try && (!w_full || w_rd);
    assign w_load   = (r_wptr != r_rptr) && (!r_dout_valid || w_rd);
    assign w_head   = r_mem[r_rptr[FIFO_DEPTH_BITS-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_word_ctr <= '0;
            r_misalign <= 1'b0;
            r_overflow <= 1'b0;
            r_dump_cnt <= '0;
        end else begin
            if (w_wr_try)  r_word_ctr <= w_idx + N_TAPS_BITS'(1);
            else if (sync) r_word_ctr <= '0;
            if ((r_state == S_RUN) && sync && (r_word_ctr != '0)) r_misalign <= 1'b1;
            if (w_wr_try && !w_wr) r_overflow <= 1'b1;
            if (w_wr && w_last)    r_dump_cnt <= r_dump_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wptr[FIFO_DEPTH_BITS-1:0]] <= {w_last, acc_in};
    end

    // r_count covers both the storage array and the output register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr       <= '0;
            r_rptr       <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_last  <= 1'b0;
            r_dout_valid <= 1'b0;
        end else begin
            if (w_wr) r_wptr <= r_wptr + PW'(1);
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            if (w_load) begin
                r_rptr       <= r_rptr + PW'(1);
                r_dout       <= w_head[W-1:0];
                r_dout_last  <= w_head[W];
                r_dout_valid <= 1'b1;
            end else if (w_rd) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

`ifdef XENG_UNLOAD_DROPCNT_EN
    logic [15:0] r_drop_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                                r_drop_cnt <= '0;
        else if (w_wr_try && !w_wr && (r_drop_cnt != 16'hFFFF)) r_drop_cnt <= r_drop_cnt + 16'd1;
    end

    assign drop_cnt = r_drop_cnt;
`else
    assign drop_cnt = '0;
`endif

    assign dout       = r_dout;
    assign dout_last  = r_dout_last;
    assign dout_valid = r_dout_valid;
    assign dump_cnt   = r_dump_cnt;
    assign overflow   = r_overflow;
    assign misalign   = r_misalign;
endmodule

// File: tb/tb_xeng_acc_unload.sv
// Directed testbench for xeng_acc_unload; honours XENG_UNLOAD_DROPCNT_EN for the drop_cnt expectation.
module tb_xeng_acc_unload;
    localparam int W = 38;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          sync = 1'b0;
    logic [W-1:0]  acc_in = '0;
    logic          valid_in = 1'b0;
    logic [W-1:0]  dout;
    logic          dout_last;
    logic          dout_valid;
    logic          dout_ready = 1'b0;
    logic [15:0]   dump_cnt;
    logic          overflow;
    logic          misalign;
    logic [15:0]   drop_cnt;

    int vec = 0;
    int err = 0;

`ifdef XENG_UNLOAD_DROPCNT_EN
    localparam logic [15:0] EXP_DROP8 = 16'd8;
`else
    localparam logic [15:0] EXP_DROP8 = 16'd0;
`endif

    xeng_acc_unload dut (
        .clk(clk), .rst(rst), .sync(sync), .acc_in(acc_in), .valid_in(valid_in),
        .dout(dout), .dout_last(dout_last), .dout_valid(dout_valid), .dout_ready(dout_ready),
        .dump_cnt(dump_cnt), .overflow(overflow), .misalign(misalign), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    // Word k: real = 7k+3, imag = 0x7FFFF-k; distinct halves catch swapped or truncated parts
    function automatic logic [W-1:0] wd(input int k);
        logic [18:0] re;
        logic [18:0] im;
        re = 19'(k * 7 + 3);
        im = 19'h7FFFF - 19'(k);
        return {re, im};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; sync = 1'b0; valid_in = 1'b0; dout_ready = 1'b0; acc_in = '0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #2;
        vec++; if (dout !== '0) begin err++; $display("FAIL reset_dout got=%h exp=0", dout); end
        vec++; if (dout_last !== 1'b0) begin err++; $display("FAIL reset_last got=%b exp=0", dout_last); end
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL reset_valid got=%b exp=0", dout_valid); end
        vec++; if (dump_cnt !== 16'd0) begin err++; $display("FAIL reset_dump_cnt got=%0d exp=0", dump_cnt); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        vec++; if (misalign !== 1'b0) begin err++; $display("FAIL reset_misalign got=%b exp=0", misalign); end
        vec++; if (drop_cnt !== 16'd0) begin err++; $display("FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        step();
        rst = 1'b0;
    endtask

    task automatic test_single_dump();
        do_reset();
        dout_ready = 1'b1;
        sync = 1'b1; step(); sync = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            valid_in = (i < 16);
            acc_in   = (i < 16) ? wd(i) : '0;
            step();
            if (i >= 1) begin
                vec++;
                if (dout_valid !== 1'b1 || dout !== wd(i-1) || dout_last !== (i-1 == 15)) begin
                    err++;
                    $display("FAIL dump_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                             i-1, dout_valid, dout, dout_last, wd(i-1), (i-1 == 15));
                end
            end else begin
                vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL dump_latency got=%b exp=0", dout_valid); end
            end
        end
        valid_in = 1'b0;
        step();
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL dump_drained got=%b exp=0", dout_valid); end
        vec++; if (dump_cnt !== 16'd1) begin err++; $display("FAIL dump_cnt got=%0d exp=1", dump_cnt); end
    endtask

    task automatic test_pre_sync();
        do_reset();
        dout_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            valid_in = 1'b1; acc_in = wd(100 + i);
            step();
            vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL presync_valid%0d got=%b exp=0", i, dout_valid); end
        end
        valid_in = 1'b0; sync = 1'b1; step(); sync = 1'b0;
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL presync_synccyc got=%b exp=0", dout_valid); end
        valid_in = 1'b1; acc_in = wd(0); step(); valid_in = 1'b0;
        step();
        vec++;
        if (dout_valid !== 1'b1 || dout !== wd(0)) begin
            err++; $display("FAIL presync_first got v=%b d=%h exp v=1 d=%h", dout_valid, dout, wd(0));
        end
        step();
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL presync_extra got=%b exp=0", dout_valid); end
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL presync_overflow got=%b exp=0", overflow); end
    endtask

    task automatic test_overflow();
        do_reset();
        sync = 1'b1; step(); sync = 1'b0;
        for (int i = 0; i < 40; i++) begin
            valid_in = 1'b1; acc_in = wd(i); step();
        end
        valid_in = 1'b0; step();
        vec++; if (overflow !== 1'b1) begin err++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        vec++; if (drop_cnt !== EXP_DROP8) begin err++; $display("FAIL ovf_drop_cnt got=%0d exp=%0d", drop_cnt, EXP_DROP8); end
        vec++; if (dump_cnt !== 16'd2) begin err++; $display("FAIL ovf_dump_cnt got=%0d exp=2", dump_cnt); end
        vec++; if (dout !== wd(0)) begin err++; $display("FAIL ovf_hold got=%h exp=%h", dout, wd(0)); end
        dout_ready = 1'b1;
        for (int j = 0; j < 32; j++) begin
            vec++;
            if (dout_valid !== 1'b1 || dout !== wd(j) || dout_last !== (j == 15 || j == 31)) begin
                err++;
                $display("FAIL ovf_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         j, dout_valid, dout, dout_last, wd(j), (j == 15 || j == 31));
            end
            step();
        end
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL ovf_drained got=%b exp=0", dout_valid); end
    endtask

    task automatic test_misalign();
        do_reset();
        dout_ready = 1'b1;
        sync = 1'b1; step(); sync = 1'b0;
        for (int k = 0; k <= 22; k++) begin
            valid_in = (k < 22);
            acc_in   = (k < 22) ? wd(k) : '0;
            sync     = (k == 5);
            step();
            sync = 1'b0;
            if (k == 4) begin
                vec++; if (misalign !== 1'b0) begin err++; $display("FAIL mis_early got=%b exp=0", misalign); end
            end
            if (k >= 1) begin
                vec++;
                if (dout !== wd(k-1) || dout_last !== (k-1 == 20)) begin
                    err++;
                    $display("FAIL mis_word%0d got d=%h l=%b exp d=%h l=%b", k-1, dout, dout_last, wd(k-1), (k-1 == 20));
                end
            end
        end
        valid_in = 1'b0;
        vec++; if (misalign !== 1'b1) begin err++; $display("FAIL mis_flag got=%b exp=1", misalign); end
        vec++; if (dump_cnt !== 16'd1) begin err++; $display("FAIL mis_dump_cnt got=%0d exp=1", dump_cnt); end
        step();
    endtask

    task automatic test_full_rw();
        do_reset();
        sync = 1'b1; step(); sync = 1'b0;
        for (int i = 0; i < 32; i++) begin
            valid_in = 1'b1; acc_in = wd(i); step();
        end
        valid_in = 1'b0; step();
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL full_no_ovf got=%b exp=0", overflow); end
        valid_in = 1'b1; acc_in = wd(32); dout_ready = 1'b1; step();
        vec++; if (overflow !== 1'b0) begin err++; $display("FAIL full_rw_ovf got=%b exp=0", overflow); end
        vec++; if (dout !== wd(1)) begin err++; $display("FAIL full_rw_next got=%h exp=%h", dout, wd(1)); end
        dout_ready = 1'b0; acc_in = wd(33); step();
        valid_in = 1'b0;
        vec++; if (overflow !== 1'b1) begin err++; $display("FAIL full_still32 got=%b exp=1", overflow); end
        dout_ready = 1'b1;
        for (int j = 1; j <= 32; j++) begin
            vec++;
            if (dout_valid !== 1'b1 || dout !== wd(j) || dout_last !== (j == 15 || j == 31)) begin
                err++;
                $display("FAIL full_word%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         j, dout_valid, dout, dout_last, wd(j), (j == 15 || j == 31));
            end
            step();
        end
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL full_drained got=%b exp=0", dout_valid); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        sync = 1'b1; step(); sync = 1'b0;
        for (int i = 0; i < 24; i++) begin
            valid_in = 1'b1; acc_in = wd(i); step();
        end
        valid_in = 1'b0; step();
        vec++; if (dump_cnt !== 16'd1 || dout_valid !== 1'b1) begin
            err++; $display("FAIL mid_pre got cnt=%0d v=%b exp cnt=1 v=1", dump_cnt, dout_valid);
        end
        #2 rst = 1'b1;
        #1;
        vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL mid_valid got=%b exp=0", dout_valid); end
        vec++; if (dout !== '0 || dout_last !== 1'b0) begin err++; $display("FAIL mid_dout got=%h l=%b exp 0", dout, dout_last); end
        vec++; if (dump_cnt !== 16'd0) begin err++; $display("FAIL mid_dump_cnt got=%0d exp=0", dump_cnt); end
        rst = 1'b0;
        dout_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            valid_in = 1'b1; acc_in = wd(50 + i); step();
            vec++; if (dout_valid !== 1'b0) begin err++; $display("FAIL mid_waitsync%0d got=%b exp=0", i, dout_valid); end
        end
        valid_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_dump();
        test_pre_sync();
        test_overflow();
        test_misalign();
        test_full_rw();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule
